pc_seq: RTL and testbench

- Parametrised program-counter sequencer for the instruction-fetch stage.
- Generalises the 4-bit jump/increment counter:
  - configurable address width, reset vector and increment stride;
  - PC-relative branches;
  - call/return through an internal return-address stack (RAS).
- Drives the instruction-memory address every cycle; the decode/control stage supplies the redirect requests.

---
 rtl/pc_pkg.sv | 24 ++
 rtl/pc_ras.sv | 68 ++++++
 rtl/pc_seq.sv | 111 +++++++++++
 tb/tb_pc_seq.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// ============================================================================
// pc_pkg : shared defaults and next-PC select encoding for the fetch sequencer
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package pc_pkg;

  localparam int PC_AW        = 8;
  localparam int PC_RESET     = 0;
  localparam int PC_STRIDE    = 1;
  localparam int PC_RAS_DEPTH = 4;

  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_BRANCH,
    SEL_JUMP,
    SEL_CALL,
    SEL_RET
  } pc_sel_e;

endpackage : pc_pkg

`default_nettype wire

// File: rtl/pc_ras.sv
// ============================================================================
// pc_ras : circular return-address stack; a push when full drops the oldest
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module pc_ras
  import pc_pkg::*;
#(
  parameter int W     = PC_AW,
  parameter int DEPTH = PC_RAS_DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] top_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] c_DEPTH = (PW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          full_q, empty_q;

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (push_i) begin
      // When full the pointer still advances, landing on the oldest entry.
      ptr_d = ptr_q + PW'(1);
      if (cnt_q != c_DEPTH) cnt_d = cnt_q + (PW+1)'(1);
    end else if (pop_i && (cnt_q != '0)) begin
      ptr_d = ptr_q - PW'(1);
      cnt_d = cnt_q - (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == c_DEPTH);
      empty_q <= (cnt_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[ptr_d] <= data_i;
  end

  assign top_o   = mem_q[ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule : pc_ras

`default_nettype wire

// File: rtl/pc_seq.sv
// ============================================================================
// pc_seq : program-counter sequencer with jump, branch and call/return via RAS
// Rev 1.0 : initial release; optional sticky fault flag under PC_FAULT_EN
// ============================================================================
`default_nettype none

module pc_seq
  import pc_pkg::*;
#(
  parameter int              AW        = PC_AW,
  parameter logic [AW-1:0]   RESET_PC  = AW'(PC_RESET),
  parameter int              STRIDE    = PC_STRIDE,
  parameter int              RAS_DEPTH = PC_RAS_DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          busy,
  input  logic          jump_flag,
  input  logic [AW-1:0] jump_addr,
  input  logic          branch_flag,
  input  logic [AW-1:0] branch_off,
  input  logic          call_flag,
  input  logic          ret_flag,
  output logic [AW-1:0] pc_out,
  output logic          ras_full,
  output logic          ras_empty
`ifdef PC_FAULT_EN
  ,
  output logic          fault
`endif
);

  localparam logic [AW-1:0] c_STRIDE = AW'(STRIDE);

  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] seq_pc;
  logic [AW-1:0] ras_top;
  logic          ras_full_w, ras_empty_w;
  logic          push, pop;
  pc_sel_e       sel;

  assign seq_pc = pc_q + c_STRIDE;

  // A return on an empty stack degrades to a sequential advance.
  always_comb begin
    sel = SEL_SEQ;
    if (ret_flag) begin
      if (!ras_empty_w) sel = SEL_RET;
    end else if (call_flag) begin
      sel = SEL_CALL;
    end else if (jump_flag) begin
      sel = SEL_JUMP;
    end else if (branch_flag) begin
      sel = SEL_BRANCH;
    end
  end

  always_comb begin
    pc_d = seq_pc;
    unique case (sel)
      SEL_RET:    pc_d = ras_top;
      SEL_CALL:   pc_d = jump_addr;
      SEL_JUMP:   pc_d = jump_addr;
      SEL_BRANCH: pc_d = pc_q + branch_off;
      default:    pc_d = seq_pc;
    endcase
  end

  assign push = !busy && (sel == SEL_CALL);
  assign pop  = !busy && (sel == SEL_RET);

  always_ff @(posedge clk) begin
    if (rst)        pc_q <= RESET_PC;
    else if (!busy) pc_q <= pc_d;
  end

  pc_ras #(
    .W     (AW),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (seq_pc),
    .top_o   (ras_top),
    .full_o  (ras_full_w),
    .empty_o (ras_empty_w)
  );

`ifdef PC_FAULT_EN
  logic fault_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fault_q <= 1'b0;
    end else if (!busy) begin
      if ((push && ras_full_w) || (ret_flag && ras_empty_w)) fault_q <= 1'b1;
    end
  end

  assign fault = fault_q;
`endif

  assign pc_out    = pc_q;
  assign ras_full  = ras_full_w;
  assign ras_empty = ras_empty_w;

endmodule : pc_seq

`default_nettype wire

// File: tb/tb_pc_seq.sv
// ============================================================================
// tb_pc_seq : vector table, corner sequences and random run against a model
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_pc_seq;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst, busy, jump_flag, branch_flag, call_flag, ret_flag;
  logic [7:0] jump_addr, branch_off;
  logic [7:0] pc_out;
  logic       ras_full, ras_empty;
`ifdef PC_FAULT_EN
  logic       fault;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_seq #(
    .AW        (8),
    .RESET_PC  (8'h10),
    .STRIDE    (1),
    .RAS_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .busy        (busy),
    .jump_flag   (jump_flag),
    .jump_addr   (jump_addr),
    .branch_flag (branch_flag),
    .branch_off  (branch_off),
    .call_flag   (call_flag),
    .ret_flag    (ret_flag),
    .pc_out      (pc_out),
    .ras_full    (ras_full),
    .ras_empty   (ras_empty)
`ifdef PC_FAULT_EN
    ,
    .fault       (fault)
`endif
  );

  typedef struct {
    logic       busy;
    logic       jf;
    logic [7:0] ja;
    logic       bf;
    logic [7:0] bo;
    logic       cf;
    logic       rf;
    logic [7:0] epc;
    logic       efull;
    logic       eempty;
  } vec_t;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drives one cycle of requests, then samples 1 time unit after the edge.
  task automatic apply(input logic b, input logic jf, input logic [7:0] ja,
                       input logic bf, input logic [7:0] bo,
                       input logic cf, input logic rf);
    busy = b; jump_flag = jf; jump_addr = ja;
    branch_flag = bf; branch_off = bo; call_flag = cf; ret_flag = rf;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    apply(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  // Behavioural model: queue of return addresses, oldest at the front.
  logic [7:0] m_pc;
  logic [7:0] m_ras[$];
  logic       m_fault;

  task automatic model_step(input logic r, input logic b, input logic jf,
                            input logic [7:0] ja, input logic bf,
                            input logic [7:0] bo, input logic cf, input logic rf);
    if (r) begin
      m_pc = 8'h10;
      m_ras.delete();
      m_fault = 1'b0;
    end else if (!b) begin
      if (rf) begin
        if (m_ras.size() > 0) begin
          m_pc = m_ras.pop_back();
        end else begin
          m_pc = m_pc + 8'd1;
          m_fault = 1'b1;
        end
      end else if (cf) begin
        if (m_ras.size() == DEPTH) begin
          void'(m_ras.pop_front());
          m_fault = 1'b1;
        end
        m_ras.push_back(m_pc + 8'd1);
        m_pc = ja;
      end else if (jf) begin
        m_pc = ja;
      end else if (bf) begin
        m_pc = m_pc + bo;
      end else begin
        m_pc = m_pc + 8'd1;
      end
    end
  endtask

  vec_t vt[$];

  initial begin
    // busy jf  ja    bf  bo    cf  rf  epc   full  empty
    vt.push_back('{0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h11, 0, 1});
    vt.push_back('{0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h12, 0, 1});
    vt.push_back('{0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h13, 0, 1});
    vt.push_back('{0, 1, 8'hFE, 0, 8'h00, 0, 0, 8'hFE, 0, 1});
    vt.push_back('{1, 1, 8'h77, 0, 8'h00, 0, 0, 8'hFE, 0, 1});
    vt.push_back('{1, 0, 8'h00, 0, 8'h00, 0, 0, 8'hFE, 0, 1});
    vt.push_back('{0, 0, 8'h00, 0, 8'h00, 0, 0, 8'hFF, 0, 1});
    vt.push_back('{0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0, 1});
    vt.push_back('{0, 0, 8'h00, 1, 8'hFC, 0, 0, 8'hFC, 0, 1});
    vt.push_back('{0, 1, 8'h20, 1, 8'h05, 0, 0, 8'h20, 0, 1});
    vt.push_back('{0, 0, 8'h40, 0, 8'h00, 1, 0, 8'h40, 0, 0});
    vt.push_back('{0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h41, 0, 0});
    vt.push_back('{0, 1, 8'h60, 0, 8'h00, 1, 0, 8'h60, 0, 0});
    vt.push_back('{0, 0, 8'h00, 0, 8'h00, 0, 1, 8'h42, 0, 0});
    vt.push_back('{0, 0, 8'h00, 0, 8'h00, 0, 1, 8'h21, 0, 1});
    vt.push_back('{0, 1, 8'h50, 0, 8'h00, 0, 0, 8'h50, 0, 1});
    vt.push_back('{0, 0, 8'h00, 0, 8'h00, 0, 1, 8'h51, 0, 1});
    vt.push_back('{0, 1, 8'h30, 0, 8'h00, 0, 0, 8'h30, 0, 1});
    vt.push_back('{0, 0, 8'h90, 0, 8'h00, 1, 0, 8'h90, 0, 0});
    vt.push_back('{0, 1, 8'h32, 0, 8'h00, 0, 0, 8'h32, 0, 0});
    vt.push_back('{0, 0, 8'h70, 0, 8'h00, 1, 0, 8'h70, 0, 0});
    vt.push_back('{0, 1, 8'h99, 0, 8'h00, 1, 1, 8'h33, 0, 0});
    vt.push_back('{0, 0, 8'h00, 0, 8'h00, 0, 1, 8'h31, 0, 1});
  end

  initial begin
    rst = 1'b1; busy = 1'b0; jump_flag = 1'b0; jump_addr = '0;
    branch_flag = 1'b0; branch_off = '0; call_flag = 1'b0; ret_flag = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_pc", pc_out, 8'h10);
    chk("reset_full", {7'd0, ras_full}, 8'd0);
    chk("reset_empty", {7'd0, ras_empty}, 8'd1);
`ifdef PC_FAULT_EN
    chk("reset_fault", {7'd0, fault}, 8'd0);
`endif
    rst = 1'b0;

    foreach (vt[i]) begin
      apply(vt[i].busy, vt[i].jf, vt[i].ja, vt[i].bf, vt[i].bo, vt[i].cf, vt[i].rf);
      chk($sformatf("vec%0d_pc", i), pc_out, vt[i].epc);
      chk($sformatf("vec%0d_full", i), {7'd0, ras_full}, {7'd0, vt[i].efull});
      chk($sformatf("vec%0d_empty", i), {7'd0, ras_empty}, {7'd0, vt[i].eempty});
    end
`ifdef PC_FAULT_EN
    chk("underflow_fault", {7'd0, fault}, 8'd1);
`endif

    // Reset with busy high clears fault; then overflow sequence.
    rst = 1'b1; busy = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_busy_pc", pc_out, 8'h10);
`ifdef PC_FAULT_EN
    chk("rst_fault_clr", {7'd0, fault}, 8'd0);
`endif
    apply(0, 1, 8'h01, 0, 8'h00, 0, 0);
    for (int k = 2; k <= 6; k++) begin
      apply(0, 0, 8'(k), 0, 8'h00, 1, 0);
      chk($sformatf("ovf_call%0d_pc", k), pc_out, 8'(k));
    end
    chk("ovf_full", {7'd0, ras_full}, 8'd1);
`ifdef PC_FAULT_EN
    chk("overflow_fault", {7'd0, fault}, 8'd1);
`endif
    for (int k = 0; k < 4; k++) begin
      apply(0, 0, 8'h00, 0, 8'h00, 0, 1);
      chk($sformatf("ovf_ret%0d_pc", k), pc_out, 8'(6 - k));
      chk($sformatf("ovf_ret%0d_full", k), {7'd0, ras_full}, 8'd0);
    end
    chk("ovf_drained_empty", {7'd0, ras_empty}, 8'd1);
    apply(0, 0, 8'h00, 0, 8'h00, 0, 1);
    chk("ovf_ret5_pc", pc_out, 8'h04);

    // Stale entries must not survive reset.
    apply(0, 0, 8'hA0, 0, 8'h00, 1, 0);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    apply(0, 0, 8'h00, 0, 8'h00, 0, 1);
    chk("stale_ret_pc", pc_out, 8'h11);
    chk("stale_ret_empty", {7'd0, ras_empty}, 8'd1);

    // Randomised run against the behavioural model.
    rst = 1'b1;
    idle();
    model_step(1'b1, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    for (int n = 0; n < 400; n++) begin
      logic r, b, jf, bf, cf, rf;
      logic [7:0] ja, bo;
      r  = ($urandom_range(0, 59) == 0);
      b  = ($urandom_range(0, 5) == 0);
      jf = ($urandom_range(0, 5) == 0);
      bf = ($urandom_range(0, 3) == 0);
      cf = ($urandom_range(0, 4) == 0);
      rf = ($urandom_range(0, 4) == 0);
      ja = 8'($urandom);
      bo = 8'($urandom);
      rst = r;
      apply(b, jf, ja, bf, bo, cf, rf);
      model_step(r, b, jf, ja, bf, bo, cf, rf);
      chk($sformatf("rnd%0d_pc", n), pc_out, m_pc);
      chk($sformatf("rnd%0d_full", n), {7'd0, ras_full},
          {7'd0, (m_ras.size() == DEPTH)});
      chk($sformatf("rnd%0d_empty", n), {7'd0, ras_empty},
          {7'd0, (m_ras.size() == 0)});
`ifdef PC_FAULT_EN
      chk($sformatf("rnd%0d_fault", n), {7'd0, fault}, {7'd0, m_fault});
`endif
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_pc_seq

`default_nettype wire
